// File: rtl/charge_accum_ctrl.sv
// charge_accum_ctrl: read-modify-write client for a 16x256 charge RAM.
// Accumulates signed deltas into addressed entries with saturation, fires and
// zeroes an entry when it reaches the threshold, and sweeps the whole RAM to
// zero after reset and on request.
module charge_accum_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic signed [DATA_W-1:0] in_delta,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     clear_done,
  output logic                     fire_valid,
  output logic [ADDR_W-1:0]        fire_addr,
  output logic                     ram_rd_en,
  output logic [ADDR_W-1:0]        ram_rd_addr,
  input  logic signed [DATA_W-1:0] ram_rd_data,
  output logic                     ram_wr_en,
  output logic [ADDR_W-1:0]        ram_wr_addr,
  output logic signed [DATA_W-1:0] ram_wr_data
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Add two DATA_W values in DATA_W+1 bits and clamp to the DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      sat_add = s[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_add = s[DATA_W-1:0];
    end
  endfunction

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDR_W-1:0]          r_clr_cnt;
  logic                       w_clr_last;
  logic                       w_accept;

  logic                       r_vld_p1;
  logic [ADDR_W-1:0]          r_addr_p1;
  logic signed [DATA_W-1:0]   r_delta_p1;

  logic                       r_wb_vld_p2;
  logic [ADDR_W-1:0]          r_wb_addr_p2;
  logic signed [DATA_W-1:0]   r_wb_data_p2;

  logic signed [DATA_W-1:0]   w_operand_p1;
  logic signed [DATA_W-1:0]   w_sum_p1;
  logic                       w_fire_p1;
  logic signed [DATA_W-1:0]   w_wdata_p1;

  assign w_clr_last  = (r_clr_cnt == ADDR_W'(DEPTH - 1));
  assign w_accept    = in_valid && in_ready;

  // ---- stage 0: accept request and launch the RAM read ----
  assign ram_rd_en   = w_accept;
  assign ram_rd_addr = in_addr;

  // ---- stage 1: forward / accumulate / threshold ----
  // The RAM returns the pre-write value when the previous request wrote the
  // same entry in the same cycle, so the last written value is forwarded.
  assign w_operand_p1 = (r_wb_vld_p2 && (r_wb_addr_p2 == r_addr_p1)) ? r_wb_data_p2
                                                                     : ram_rd_data;
  assign w_sum_p1     = sat_add(w_operand_p1, r_delta_p1);
  assign w_fire_p1    = r_vld_p1 && (w_sum_p1 >= threshold);
  assign w_wdata_p1   = w_fire_p1 ? '0 : w_sum_p1;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a clear_req outside RUN is dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clr_last) w_state_nxt = S_RUN;
      S_RUN:   if (clear_req) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_vld_p1) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // FSM outputs: the sweep counter owns the write port in CLEAR, stage 1 otherwise.
  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b1;
    ram_wr_en   = 1'b0;
    ram_wr_addr = r_addr_p1;
    ram_wr_data = w_wdata_p1;
    case (r_state)
      S_CLEAR: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = r_clr_cnt;
        ram_wr_data = '0;
      end
      S_RUN: begin
        in_ready  = !clear_req;
        busy      = 1'b0;
        ram_wr_en = r_vld_p1;
      end
      S_DRAIN: begin
        ram_wr_en = r_vld_p1;
      end
      default: begin
        ram_wr_en = 1'b0;
      end
    endcase
  end

  // Clear sweep counter and the completion pulse after its last write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_cnt  <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= (r_state == S_CLEAR) && w_clr_last;
      if (r_state == S_CLEAR) begin
        r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + ADDR_W'(1);
      end
    end
  end

  // Pipeline valids and the registered fire event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1    <= 1'b0;
      r_wb_vld_p2 <= 1'b0;
      fire_valid  <= 1'b0;
      fire_addr   <= '0;
    end else begin
      r_vld_p1    <= w_accept;
      r_wb_vld_p2 <= r_vld_p1;
      fire_valid  <= w_fire_p1;
      if (w_fire_p1) begin
        fire_addr <= r_addr_p1;
      end
    end
  end

  // Pipeline data registers; qualified by the valids, so left unreset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr_p1  <= in_addr;
      r_delta_p1 <= in_delta;
    end
    // ---- stage 2: write-back copy for forwarding ----
    if (r_vld_p1) begin
      r_wb_addr_p2 <= r_addr_p1;
      r_wb_data_p2 <= w_wdata_p1;
    end
  end

endmodule

// File: tb/tb_charge_accum_ctrl.sv
// Testbench for charge_accum_ctrl: behavioural charge RAM, stimulus process
// pushing hand-computed expected writes/fires, and a monitor that pops and
// compares whenever the DUT writes the RAM or fires.
module tb_charge_accum_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_addr;
  logic signed [15:0] in_delta;
  logic signed [15:0] threshold;
  logic               clear_req;
  logic               busy;
  logic               clear_done;
  logic               fire_valid;
  logic [7:0]         fire_addr;
  logic               ram_rd_en;
  logic [7:0]         ram_rd_addr;
  logic signed [15:0] ram_rd_data;
  logic               ram_wr_en;
  logic [7:0]         ram_wr_addr;
  logic signed [15:0] ram_wr_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cd_count = 0;
  bit fill;

  logic signed [15:0] mem [256];

  typedef struct {
    logic [7:0]         a;
    logic signed [15:0] d;
    int                 c;
  } wr_t;

  typedef struct {
    logic [7:0] a;
    int         c;
  } fire_t;

  wr_t   exp_wr[$];
  fire_t exp_fire[$];

  charge_accum_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_delta   (in_delta),
    .threshold  (threshold),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .fire_valid (fire_valid),
    .fire_addr  (fire_addr),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Charge RAM: 1-cycle read, read-before-write, garbage contents at start.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(16'h5A00 + i);
    end else begin
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end
  end

  always @(negedge clk) begin
    if (clear_done) cd_count <= cd_count + 1;
  end

  // Monitor: compare every RAM write and fire event against the queues.
  always @(negedge clk) begin
    wr_t   w;
    fire_t f;
    if (ram_wr_en) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected addr=%0d data=%0d cyc=%0d", ram_wr_addr, ram_wr_data, cyc);
      end else begin
        w = exp_wr.pop_front();
        if (ram_wr_addr !== w.a || ram_wr_data !== w.d || (w.c >= 0 && cyc != w.c)) begin
          failures++;
          $display("FAIL wr got addr=%0d data=%0d cyc=%0d, exp addr=%0d data=%0d cyc=%0d",
                   ram_wr_addr, ram_wr_data, cyc, w.a, w.d, w.c);
        end
      end
    end
    if (fire_valid) begin
      checks++;
      if (exp_fire.size() == 0) begin
        failures++;
        $display("FAIL fire_unexpected addr=%0d cyc=%0d", fire_addr, cyc);
      end else begin
        f = exp_fire.pop_front();
        if (fire_addr !== f.a || cyc != f.c) begin
          failures++;
          $display("FAIL fire got addr=%0d cyc=%0d, exp addr=%0d cyc=%0d",
                   fire_addr, cyc, f.a, f.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic push_clears();
    wr_t w;
    for (int i = 0; i < 256; i++) begin
      w.a = 8'(i);
      w.d = '0;
      w.c = -1;
      exp_wr.push_back(w);
    end
  endtask

  // Issue one request at posedge+1; it is accepted at the next posedge.
  task automatic req(input logic [7:0] a, input logic signed [15:0] d,
                     input logic signed [15:0] e, input bit f);
    wr_t   w;
    fire_t fe;
    in_valid = 1'b1;
    in_addr  = a;
    in_delta = d;
    w.a = a;
    w.d = e;
    w.c = cyc + 1;
    exp_wr.push_back(w);
    if (f) begin
      fe.a = a;
      fe.c = cyc + 2;
      exp_fire.push_back(fe);
    end
    chk("req_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count negedges with busy high; returns at the first negedge with busy low.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_delta  = '0;
    threshold = 16'sd1000;
    clear_req = 1'b0;
    fill      = 1'b1;
    push_clears();
    @(posedge clk);
    #1;
    fill = 1'b0;
    @(negedge clk);
    chk("rst_busy",       32'(busy),       32'd1);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_fire_valid", 32'(fire_valid), 32'd0);
    chk("rst_fire_addr",  32'(fire_addr),  32'd0);
    chk("rst_wr_en",      32'(ram_wr_en),  32'd0);
    chk("rst_rd_en",      32'(ram_rd_en),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Initial sweep: INIT + 256 clear writes.
    wait_idle(n);
    chk("init_busy_cycles", 32'(n),          32'd257);
    chk("init_clear_done",  32'(clear_done), 32'd1);
    chk("init_in_ready",    32'(in_ready),   32'd1);
    @(posedge clk);
    #1;
    chk("init_cd_count", 32'(cd_count), 32'd1);

    // Separated requests go through the RAM path.
    req(8'd5, 16'sd100, 16'sd100, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    req(8'd5, 16'sd23, 16'sd123, 1'b0);

    // Back-to-back forwarding, then an interleaved address.
    req(8'd7, 16'sd10, 16'sd10, 1'b0);
    req(8'd7, 16'sd20, 16'sd30, 1'b0);
    req(8'd7, 16'sd30, 16'sd60, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    req(8'd7, -16'sd50, 16'sd10, 1'b0);
    req(8'd8, 16'sd1,   16'sd1,  1'b0);
    req(8'd7, 16'sd5,   16'sd15, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // clear_req with a same-cycle request while s1 holds a request.
    begin
      wr_t w;
      in_valid = 1'b1;
      in_addr  = 8'd20;
      in_delta = 16'sd7;
      w.a = 8'd20;
      w.d = 16'sd7;
      w.c = cyc + 1;
      exp_wr.push_back(w);
      @(posedge clk);
      #1;
      in_addr   = 8'd21;
      in_delta  = 16'sd99;
      clear_req = 1'b1;
      #1;
      chk("clr_ready_drop", 32'(in_ready), 32'd0);
      push_clears();
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      clear_req = 1'b0;
      chk("clr_busy", 32'(busy), 32'd1);
      repeat (100) @(posedge clk);
      #1;
      threshold = 16'sd50;
      clear_req = 1'b1;
      @(posedge clk);
      #1;
      clear_req = 1'b0;
      wait_idle(n);
      chk("clr_clear_done", 32'(clear_done), 32'd1);
      chk("clr_in_ready",   32'(in_ready),   32'd1);
      @(posedge clk);
      #1;
      chk("clr_cd_count", 32'(cd_count), 32'd2);
    end

    // Threshold 50: second write zeroes the entry and fires.
    req(8'd3, 16'sd30, 16'sd30, 1'b0);
    req(8'd3, 16'sd25, 16'sd0,  1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Plain clear to change threshold while busy.
    clear_req = 1'b1;
    push_clears();
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    threshold = 16'sd32767;
    wait_idle(n);
    chk("clr2_busy_cycles", 32'(n), 32'd257);
    @(posedge clk);
    #1;

    // Saturation at both rails; positive rail equals threshold and fires.
    req(8'd9, 16'sd30000,  16'sd30000,  1'b0);
    req(8'd9, 16'sd30000,  16'sd0,      1'b1);
    req(8'd9, -16'sd30000, -16'sd30000, 1'b0);
    req(8'd9, -16'sd30000, 16'sh8000,   1'b0);
    req(8'd9, -16'sd30000, 16'sh8000,   1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("wr_queue_empty",   32'(exp_wr.size()),   32'd0);
    chk("fire_queue_empty", 32'(exp_fire.size()), 32'd0);
    chk("cd_total",         32'(cd_count),        32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
